mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory (same interface as IMEM/DMEM: memRead, memWrite, addrUnit,
//  address, dataIn, dataOut) between the rvMagic fetch port and data port. Enables a unified
//  instruction/data memory.
//  Arbitrates per cycle and drives the memory directly.
//  Tracks the single in-flight access so that each response returns to its owner.
// PARAMETERS
//  ADDR_WIDTH      32  requester address width (`ADDR_WIDTH)
//  MEM_ADDR_WIDTH  10  memory address width; requester address truncated to [MEM_ADDR_WIDTH-1:0]
//  WORD_WIDTH      32  data width (`WORD_WIDTH)
//  MODE_WIDTH      2   memory mode width (`MEMORY_MODE_WIDTH)
//  STARVE_LIMIT    4   max consecutive cycles if_req may wait before forced grant (>=1)
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               synchronous reset, active-high
//  if_req         in   1               fetch read request; addr held stable until if_gnt
//  if_addr        in   ADDR_WIDTH      fetch address (always WORD mode)
//  if_gnt         out  1               fetch request accepted this cycle
//  if_rvalid      out  1               fetch read data valid (1 cycle after if_gnt)
//  if_rdata       out  WORD_WIDTH      fetch read data; holds last value until next if_rvalid
//  d_req          in   1               data request; d_* held stable until d_gnt
//  d_we           in   1               1 = write, 0 = read
//  d_mode         in   MODE_WIDTH      byte/half/word mode
//  d_addr         in   ADDR_WIDTH      data address
//  d_wdata        in   WORD_WIDTH      write data
//  d_gnt          out  1               data request accepted this cycle
//  d_rvalid       out  1               read data valid / write ack (1 cycle after d_gnt)
//  d_rdata        out  WORD_WIDTH      data read data; holds until next data read response
//  mem_memRead    out  1               to memory
//  mem_memWrite   out  1               to memory
//  mem_addrUnit   out  MODE_WIDTH      to memory
//  mem_address    out  MEM_ADDR_WIDTH  to memory
//  mem_dataIn     out  WORD_WIDTH      to memory (write data)
//  mem_dataOut    in   WORD_WIDTH      from memory; valid the cycle after memRead is sampled
// BEHAVIOUR
//  - Reset: all outputs 0.
//    Response FSM to IDLE, starve counter 0, RR pointer = IF. Any in-flight response is dropped;
//    no rvalid on the cycle after reset.
//  - gnt is combinational from req and arbitration state; at most one gnt per cycle.
//    In the grant cycle the memory controls carry the winner's request:
//    - IF: memRead=1, addrUnit=`WORD_MEMORY_MODE.
//    - D:  memRead=~d_we, memWrite=d_we, addrUnit=d_mode, dataIn=d_wdata.
//    With no grant, memRead=memWrite=0 and address/dataIn hold their previous values.
//  - Back-to-back grants are allowed: a new grant may issue in the same cycle as the previous
//    rvalid. Throughput is 1 access/cycle.
//  - Response FSM states:
//    IDLE
//    RESP_IF: rvalid to IF next cycle
//    RESP_D_RD: rvalid + data to D
//    RESP_D_WR: ack only, d_rdata unchanged
//    Next state is set from the grant each cycle; IDLE if none.
//  - In a RESP_* cycle, rdata = mem_dataOut (pass-through). A per-port hold register captures
//    it at that edge and drives rdata afterwards.
//  - Arbitration (default, fixed priority): D beats IF. Starve counter increments each cycle
//    if_req=1 && !if_gnt and clears on if_gnt or !if_req. When counter==STARVE_LIMIT, IF wins
//    the next contention.
//  - Simultaneous req with only one present: that one is granted immediately, with no idle
//    bubble.
//  - A req withdrawn before gnt is a protocol error. The bench asserts against it; the RTL
//    ignores the withdrawn req.
//  - Address bits above MEM_ADDR_WIDTH are discarded, with no error.
// CONFIGURATION
//  MEM_PORT_ARB_RR_EN defined:
//    - Round-robin replaces fixed priority.
//    - On contention, the port not granted last wins. The pointer updates on every grant.
//    - Starve counter and STARVE_LIMIT are unused and the counter is not synthesized.
//  Undefined: fixed D>IF priority with the starvation guard.
// STRUCTURE
//  - mem_arb_pkg holds:
//    - typedef enum {IDLE, RESP_IF, RESP_D_RD, RESP_D_WR} resp_state_t
//    - typedef enum {OWNER_IF, OWNER_D} owner_t
//  - Width macros come from rv32i_defs.sv.
//  - One sub-module, arb_pick2: two-input grant logic, fixed-priority plus starve counter, or
//    RR pointer under the macro.
//  - FSM, memory muxing and hold registers stay in the top.
// TESTING
//  1 Reset: rst=1 with both reqs high -> all gnt/rvalid/mem_* = 0.
//    Release -> D granted first.
//  2 Lone fetch: if_req, if_addr=0x8 -> if_gnt same cycle, mem_memRead=1, mem_address=0x8.
//    Next cycle if_rvalid=1 and if_rdata=mem word[2]; held after req drops.
//  3 Contention, fixed priority: both req held, STARVE_LIMIT=4.
//    Grants D,D,D,D then IF on the 5th cycle. Responses route to the correct port with no
//    data swap.
//  4 Data write then read: d_we=1 addr 0x10 wdata 0xDEADBEEF -> d_gnt, memWrite=1, d_rvalid
//    next cycle, d_rdata unchanged. Then read 0x10 -> d_rdata=0xDEADBEEF.
//  5 Reset mid-operation: rst asserted in the cycle after if_gnt -> if_rvalid stays 0 and FSM
//    goes to IDLE.
//  6 With MEM_PORT_ARB_RR_EN: both req held -> grants alternate IF,D,IF,D starting with IF
//    after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for mem_port_arbiter.
//   Width/mode macros normally come from rv32i_defs.sv; the fallbacks below
//   keep the package self-contained when that file is not part of the build.
//   Exports: ADDR_W, WORD_W, MODE_W, WORD_MODE, resp_state_t, owner_t.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef MEMORY_MODE_WIDTH
`define MEMORY_MODE_WIDTH 2
`endif
`ifndef WORD_MEMORY_MODE
`define WORD_MEMORY_MODE 2'b10
`endif

package mem_arb_pkg;
   localparam int ADDR_W = `ADDR_WIDTH;
   localparam int WORD_W = `WORD_WIDTH;
   localparam int MODE_W = `MEMORY_MODE_WIDTH;
   localparam logic [MODE_W-1:0] WORD_MODE = `WORD_MEMORY_MODE;

   // Which response the memory owes on the next cycle
   typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D_RD, RESP_D_WR} resp_state_t;

   typedef enum logic {OWNER_IF, OWNER_D} owner_t;
endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: two-requester grant logic for the shared memory port.
//   Default: data port beats fetch port; a starve counter forces a fetch
//   grant after STARVE_LIMIT consecutive lost cycles.
//   MEM_PORT_ARB_RR_EN defined: round-robin pointer, no starve counter.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   ifReq/dReq requests (fetch / data)
//   ifGnt/dGnt combinational grants, at most one high, both low in reset
module arb_pick2
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ifReq,
   input  logic dReq,
   output logic ifGnt,
   output logic dGnt
);

`ifdef MEM_PORT_ARB_RR_EN
   // prio names the port that wins the next contention
   owner_t prio;

   always_ff @(posedge clk) begin
      if (rst)        prio <= OWNER_IF;
      else if (ifGnt) prio <= OWNER_D;
      else if (dGnt)  prio <= OWNER_IF;
   end

   always_comb begin
      ifGnt = 1'b0;
      dGnt  = 1'b0;
      if (!rst) begin
         if (ifReq && dReq) begin
            ifGnt = (prio == OWNER_IF);
            dGnt  = (prio == OWNER_D);
         end else begin
            ifGnt = ifReq;
            dGnt  = dReq;
         end
      end
   end
`else
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starveCnt;
   logic          starved;

   assign starved = (starveCnt >= CW'(STARVE_LIMIT));

   always_comb begin
      ifGnt = 1'b0;
      dGnt  = 1'b0;
      if (!rst) begin
         ifGnt = ifReq && (!dReq || starved);
         dGnt  = dReq && !ifGnt;
      end
   end

   // Counts cycles fetch waited; saturates, although a starved fetch always
   // wins its next cycle so the limit is never exceeded in practice.
   always_ff @(posedge clk) begin
      if (rst || !ifReq || ifGnt) starveCnt <= '0;
      else if (!starved)          starveCnt <= starveCnt + CW'(1);
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port
//   (if_*) and the data port (d_*). One access granted per cycle; the
//   response FSM remembers who owns the in-flight access so the read data
//   (valid one cycle after the grant) is routed back to its owner.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_req/addr/gnt     fetch request (word reads only)
//   if_rvalid/rdata     fetch response, rdata held between responses
//   d_req/we/mode/addr/wdata/gnt  data request
//   d_rvalid/rdata      data response (write ack leaves rdata unchanged)
//   mem_*               memory interface (memRead/memWrite/addrUnit/address/
//                       dataIn out, dataOut in)
// Config macro: MEM_PORT_ARB_RR_EN selects round-robin arbitration.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_W,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int WORD_WIDTH     = WORD_W,
   parameter int MODE_WIDTH     = MODE_W,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_req,
   input  logic [ADDR_WIDTH-1:0]     if_addr,
   output logic                      if_gnt,
   output logic                      if_rvalid,
   output logic [WORD_WIDTH-1:0]     if_rdata,
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic [MODE_WIDTH-1:0]     d_mode,
   input  logic [ADDR_WIDTH-1:0]     d_addr,
   input  logic [WORD_WIDTH-1:0]     d_wdata,
   output logic                      d_gnt,
   output logic                      d_rvalid,
   output logic [WORD_WIDTH-1:0]     d_rdata,
   output logic                      mem_memRead,
   output logic                      mem_memWrite,
   output logic [MODE_WIDTH-1:0]     mem_addrUnit,
   output logic [MEM_ADDR_WIDTH-1:0] mem_address,
   output logic [WORD_WIDTH-1:0]     mem_dataIn,
   input  logic [WORD_WIDTH-1:0]     mem_dataOut
);

   resp_state_t               state, stateNext;
   logic [MEM_ADDR_WIDTH-1:0] addrHold;
   logic [WORD_WIDTH-1:0]     dataHold;
   logic [WORD_WIDTH-1:0]     ifHold;
   logic [WORD_WIDTH-1:0]     dHold;

   // High address bits are deliberately dropped
   logic unusedAddrHi;
   assign unusedAddrHi = ^{if_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                           d_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

   arb_pick2 #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) uPick (
      .clk   (clk),
      .rst   (rst),
      .ifReq (if_req),
      .dReq  (d_req),
      .ifGnt (if_gnt),
      .dGnt  (d_gnt)
   );

   // Response FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Response FSM: next state follows this cycle's grant
   always_comb begin
      stateNext = IDLE;
      if (if_gnt)     stateNext = RESP_IF;
      else if (d_gnt) stateNext = d_we ? RESP_D_WR : RESP_D_RD;
   end

   // Response FSM outputs and memory-side muxing
   always_comb begin
      mem_memRead  = 1'b0;
      mem_memWrite = 1'b0;
      mem_addrUnit = '0;
      mem_address  = addrHold;
      mem_dataIn   = dataHold;
      if_rvalid    = 1'b0;
      d_rvalid     = 1'b0;
      if_rdata     = ifHold;
      d_rdata      = dHold;
      if (rst) begin
         // Hold registers only clear at the first reset edge; force zero now
         mem_address = '0;
         mem_dataIn  = '0;
         if_rdata    = '0;
         d_rdata     = '0;
      end else begin
         if (if_gnt) begin
            mem_memRead  = 1'b1;
            mem_addrUnit = WORD_MODE;
            mem_address  = if_addr[MEM_ADDR_WIDTH-1:0];
         end else if (d_gnt) begin
            mem_memRead  = ~d_we;
            mem_memWrite = d_we;
            mem_addrUnit = d_mode;
            mem_address  = d_addr[MEM_ADDR_WIDTH-1:0];
            mem_dataIn   = d_wdata;
         end
         case (state)
            RESP_IF: begin
               if_rvalid = 1'b1;
               if_rdata  = mem_dataOut;
            end
            RESP_D_RD: begin
               d_rvalid = 1'b1;
               d_rdata  = mem_dataOut;
            end
            RESP_D_WR: d_rvalid = 1'b1;
            default: ;
         endcase
      end
   end

   // Address/data hold so the memory bus stays quiet between grants, and
   // per-port read data hold so rdata survives until the next response.
   always_ff @(posedge clk) begin
      if (rst) begin
         addrHold <= '0;
         dataHold <= '0;
         ifHold   <= '0;
         dHold    <= '0;
      end else begin
         if (if_gnt || d_gnt)       addrHold <= mem_address;
         if (d_gnt)                 dataHold <= d_wdata;
         if (state == RESP_IF)      ifHold   <= mem_dataOut;
         if (state == RESP_D_RD)    dHold    <= mem_dataOut;
      end
   end

endmodule
